// File: rtl/np_pkg.sv
// Shared constants and loader state encoding for the np core program loader.
package np_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned ADDRSIZE = 12;
    localparam int unsigned MEMSIZE  = 1 << ADDRSIZE;
    localparam int unsigned BYTEW    = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CHK,
        RUN
    } ld_state_e;

endpackage

// File: rtl/np_prog_loader_if.sv
// Byte-stream valid/ready handshake between a program source and the loader.
interface np_prog_loader_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);

endinterface

// File: rtl/np_imem.sv
// Instruction store: one synchronous write port, one asynchronous read port.
module np_imem #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [WIDTH-1:0]    rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents deliberately survive reset so a core can be restarted on the same image.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/np_prog_loader.sv
// Program loader: assembles a byte stream into instruction words and holds the
// core in reset until loaded. Define NP_LOADER_CHK_EN for a trailing XOR checksum byte.
module np_prog_loader #(
    parameter int unsigned WIDTH    = np_pkg::WIDTH,
    parameter int unsigned ADDRSIZE = np_pkg::ADDRSIZE
) (
    input  logic                clk,
    input  logic                reset,
    np_prog_loader_if.slave     rx,
    input  logic [ADDRSIZE-1:0] instr_addr,
    output logic [WIDTH-1:0]    instr_data,
    output logic                cpu_reset,
    input  logic                cpu_halt,
    output logic                load_done,
    output logic                load_err,
    output logic [ADDRSIZE:0]   word_count
);

    import np_pkg::*;

    localparam int unsigned CNTW  = ADDRSIZE + 1;
    localparam int unsigned MEMSZ = 1 << ADDRSIZE;

    ld_state_e         state_q, state_d;
    logic [CNTW-1:0]   waddr_q, waddr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        hdr_hi_q, hdr_hi_d;
    logic [CNTW-1:0]   word_count_q, word_count_d;
    logic              load_err_q, load_err_d;
    logic              rx_ready_q, rx_ready_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
`ifdef NP_LOADER_CHK_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic              rx_fire;
    logic [15:0]       hdr_n;
    logic              hdr_ok;
    logic [CNTW-1:0]   waddr_inc;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;

    assign rx_fire   = rx.rx_valid && rx_ready_q;
    assign hdr_n     = {hdr_hi_q, rx.rx_data};
    assign hdr_ok    = (hdr_n != 16'd0) && (32'(hdr_n) <= MEMSZ);
    assign waddr_inc = waddr_q + CNTW'(1);
    assign mem_wdata = WIDTH'({shift_q, rx.rx_data});

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        hdr_hi_d     = hdr_hi_q;
        word_count_d = word_count_q;
        load_err_d   = load_err_q;
        mem_we       = 1'b0;
`ifdef NP_LOADER_CHK_EN
        chk_d        = chk_q;
`endif

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    hdr_hi_d   = rx.rx_data;
                    load_err_d = 1'b0;
                    waddr_d    = '0;
                    byte_idx_d = '0;
`ifdef NP_LOADER_CHK_EN
                    chk_d      = '0;
`endif
                    state_d    = HDR;
                end
            end
            HDR: begin
                if (rx_fire) begin
                    if (hdr_ok) begin
                        word_count_d = CNTW'(hdr_n);
                        state_d      = PAYLOAD;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_fire) begin
                    shift_d    = {shift_q[15:0], rx.rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef NP_LOADER_CHK_EN
                    chk_d      = chk_q ^ rx.rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        mem_we  = 1'b1;
                        waddr_d = waddr_inc;
                        if (waddr_inc == word_count_q) begin
`ifdef NP_LOADER_CHK_EN
                            state_d = CHK;
`else
                            state_d = RUN;
`endif
                        end
                    end
                end
            end
`ifdef NP_LOADER_CHK_EN
            CHK: begin
                if (rx_fire) begin
                    if (rx.rx_data == chk_q) begin
                        state_d = RUN;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
`endif
            RUN: begin
                if (cpu_halt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rx_ready_d  = (state_d != RUN);
        cpu_reset_d = (state_d != RUN);
        load_done_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            hdr_hi_q     <= '0;
            word_count_q <= '0;
            load_err_q   <= 1'b0;
            rx_ready_q   <= 1'b1;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
`ifdef NP_LOADER_CHK_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            hdr_hi_q     <= hdr_hi_d;
            word_count_q <= word_count_d;
            load_err_q   <= load_err_d;
            rx_ready_q   <= rx_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
`ifdef NP_LOADER_CHK_EN
            chk_q        <= chk_d;
`endif
        end
    end

    np_imem #(
        .WIDTH    (WIDTH),
        .ADDRSIZE (ADDRSIZE)
    ) u_imem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (waddr_q[ADDRSIZE-1:0]),
        .wdata   (mem_wdata),
        .raddr   (instr_addr),
        .rdata_c (instr_data)
    );

    assign rx.rx_ready = rx_ready_q;
    assign cpu_reset   = cpu_reset_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_np_prog_loader.sv
// Directed bench for np_prog_loader; follows NP_LOADER_CHK_EN when defined.
module tb_np_prog_loader;

    localparam int unsigned AW = np_pkg::ADDRSIZE;
    localparam int unsigned DW = np_pkg::WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_data;
    logic          cpu_reset;
    logic          cpu_halt;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;

    int vectors = 0;
    int errors  = 0;
    int acc_cnt = 0;

    np_prog_loader_if rx();

    np_prog_loader #(.WIDTH(DW), .ADDRSIZE(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .cpu_reset  (cpu_reset),
        .cpu_halt   (cpu_halt),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && rx.rx_valid && rx.rx_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int guard;
        rx.rx_valid = 1'b0;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        rx.rx_valid = 1'b1;
        rx.rx_data  = b;
        guard = 0;
        while (!rx.rx_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            errors++;
            $display("FAIL rx_ready_timeout: byte %h never accepted, rx_ready=%b want 1", b, rx.rx_ready);
        end
        tick();
        rx.rx_valid = 1'b0;
    endtask

    task automatic send_prog(input logic [15:0] n, input logic [31:0] w[$], input int gap_max);
        logic [7:0]  x;
        logic [31:0] word;
        x = 8'h00;
        send_byte(n[15:8], gap_max);
        send_byte(n[7:0], gap_max);
        foreach (w[i]) begin
            word = w[i];
            for (int b = 3; b >= 0; b--) begin
                send_byte(8'(word >> (8 * b)), gap_max);
                x = x ^ 8'(word >> (8 * b));
            end
        end
`ifdef NP_LOADER_CHK_EN
        send_byte(x, gap_max);
`endif
    endtask

    task automatic fetch(input logic [AW-1:0] a, output logic [DW-1:0] d);
        instr_addr = a;
        #1;
        d = instr_data;
    endtask

    task automatic halt_pulse();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        vectors++; if (rx.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx.rx_ready); end
        vectors++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", load_err); end
        vectors++; if (word_count !== 13'd0) begin errors++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    endtask

    task automatic test_basic_load();
        logic [7:0]    s[$];
        logic [DW-1:0] d;
        int            start;
        s = '{8'h00, 8'h02, 8'h30, 8'h00, 8'h10, 8'h00, 8'hB0, 8'h00, 8'h00, 8'h00};
`ifdef NP_LOADER_CHK_EN
        s.push_back(8'h90);
`endif
        foreach (s[i]) begin
            if (i == s.size() - 1) begin
                vectors++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_pre_last_cpu_reset: got %b want 1", cpu_reset); end
            end
            send_byte(s[i], 0);
        end
        vectors++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_load_done: got %b want 1", load_done); end
        vectors++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_cpu_reset: got %b want 0", cpu_reset); end
        vectors++; if (rx.rx_ready !== 1'b0) begin errors++; $display("FAIL basic_rx_ready: got %b want 0", rx.rx_ready); end
        vectors++; if (word_count !== 13'd2) begin errors++; $display("FAIL basic_word_count: got %0d want 2", word_count); end
        fetch(12'd0, d);
        vectors++; if (d !== 32'h30001000) begin errors++; $display("FAIL basic_mem0: got %h want 30001000", d); end
        fetch(12'd1, d);
        vectors++; if (d !== 32'hB0000000) begin errors++; $display("FAIL basic_mem1: got %h want b0000000", d); end
        // Bytes offered while running must not be consumed.
        start = acc_cnt;
        rx.rx_valid = 1'b1;
        rx.rx_data  = 8'hEE;
        repeat (3) tick();
        rx.rx_valid = 1'b0;
        vectors++; if (acc_cnt - start !== 0) begin errors++; $display("FAIL run_ignore_rx: consumed %0d want 0", acc_cnt - start); end
        vectors++; if (load_done !== 1'b1) begin errors++; $display("FAIL run_stays: load_done got %b want 1", load_done); end
    endtask

    task automatic test_halt_reload();
        logic [31:0]   w[$];
        logic [DW-1:0] d;
        halt_pulse();
        vectors++; if (rx.rx_ready !== 1'b1) begin errors++; $display("FAIL halt_rx_ready: got %b want 1", rx.rx_ready); end
        vectors++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL halt_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (load_done !== 1'b0) begin errors++; $display("FAIL halt_load_done: got %b want 0", load_done); end
        w = '{32'hDEADBEEF};
        send_prog(16'd1, w, 0);
        vectors++; if (load_done !== 1'b1) begin errors++; $display("FAIL reload_load_done: got %b want 1", load_done); end
        vectors++; if (word_count !== 13'd1) begin errors++; $display("FAIL reload_word_count: got %0d want 1", word_count); end
        fetch(12'd0, d);
        vectors++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL reload_mem0: got %h want deadbeef", d); end
        fetch(12'd1, d);
        vectors++; if (d !== 32'hB0000000) begin errors++; $display("FAIL reload_mem1: got %h want b0000000", d); end
    endtask

    task automatic test_bad_header();
        logic [DW-1:0] d;
        halt_pulse();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL hdr0_load_err: got %b want 1", load_err); end
        vectors++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL hdr0_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (rx.rx_ready !== 1'b1) begin errors++; $display("FAIL hdr0_rx_ready: got %b want 1", rx.rx_ready); end
        send_byte(8'h10, 0);
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL hdr_byte0_clears_err: got %b want 0", load_err); end
        send_byte(8'h01, 0);
        vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL hdr4097_load_err: got %b want 1", load_err); end
        vectors++; if (load_done !== 1'b0) begin errors++; $display("FAIL hdr4097_load_done: got %b want 0", load_done); end
        // Halt outside RUN has no effect.
        halt_pulse();
        vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL idle_halt_load_err: got %b want 1", load_err); end
        fetch(12'd0, d);
        vectors++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL badhdr_mem0: got %h want deadbeef", d); end
    endtask

    task automatic test_gaps();
        logic [31:0]   w[$];
        logic [DW-1:0] d;
        int            start;
        int            want;
        w = '{32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C};
        want = 14;
`ifdef NP_LOADER_CHK_EN
        want = 15;
`endif
        start = acc_cnt;
        send_prog(16'd3, w, 3);
        vectors++; if (acc_cnt - start !== want) begin errors++; $display("FAIL gaps_consumed: got %0d want %0d", acc_cnt - start, want); end
        vectors++; if (load_done !== 1'b1) begin errors++; $display("FAIL gaps_load_done: got %b want 1", load_done); end
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL gaps_load_err: got %b want 0", load_err); end
        vectors++; if (word_count !== 13'd3) begin errors++; $display("FAIL gaps_word_count: got %0d want 3", word_count); end
        for (int i = 0; i < 3; i++) begin
            fetch(12'(i), d);
            vectors++; if (d !== w[i]) begin errors++; $display("FAIL gaps_mem%0d: got %h want %h", i, d, w[i]); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0]   w[$];
        logic [DW-1:0] d;
        logic [7:0]    s[$];
        halt_pulse();
        // N = MEMSIZE is the largest legal header.
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL hdr4096_load_err: got %b want 0", load_err); end
        vectors++; if (word_count !== 13'd4096) begin errors++; $display("FAIL hdr4096_word_count: got %0d want 4096", word_count); end
        s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (s[i]) send_byte(s[i], 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (rx.rx_ready !== 1'b1) begin errors++; $display("FAIL midrst_rx_ready: got %b want 1", rx.rx_ready); end
        vectors++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL midrst_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (load_done !== 1'b0) begin errors++; $display("FAIL midrst_load_done: got %b want 0", load_done); end
        vectors++; if (word_count !== 13'd0) begin errors++; $display("FAIL midrst_word_count: got %0d want 0", word_count); end
        fetch(12'd0, d);
        vectors++; if (d !== 32'h11223344) begin errors++; $display("FAIL midrst_mem0: got %h want 11223344", d); end
        fetch(12'd1, d);
        vectors++; if (d !== 32'h89ABCDEF) begin errors++; $display("FAIL midrst_mem1: got %h want 89abcdef", d); end
        w = '{32'hCAFEF00D};
        send_prog(16'd1, w, 0);
        fetch(12'd0, d);
        vectors++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL postrst_mem0: got %h want cafef00d", d); end
        fetch(12'd1, d);
        vectors++; if (d !== 32'h89ABCDEF) begin errors++; $display("FAIL postrst_mem1: got %h want 89abcdef", d); end
        vectors++; if (load_done !== 1'b1) begin errors++; $display("FAIL postrst_load_done: got %b want 1", load_done); end
    endtask

`ifdef NP_LOADER_CHK_EN
    task automatic test_checksum();
        logic [7:0] s[$];
        halt_pulse();
        s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        foreach (s[i]) send_byte(s[i], 0);
        vectors++; if (load_done !== 1'b1) begin errors++; $display("FAIL chk_good_load_done: got %b want 1", load_done); end
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL chk_good_load_err: got %b want 0", load_err); end
        halt_pulse();
        s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        foreach (s[i]) send_byte(s[i], 0);
        vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL chk_bad_load_err: got %b want 1", load_err); end
        vectors++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL chk_bad_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (rx.rx_ready !== 1'b1) begin errors++; $display("FAIL chk_bad_rx_ready: got %b want 1", rx.rx_ready); end
        vectors++; if (load_done !== 1'b0) begin errors++; $display("FAIL chk_bad_load_done: got %b want 0", load_done); end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
        cpu_halt    = 1'b0;
        instr_addr  = '0;
        test_reset();
        test_basic_load();
        test_halt_reload();
        test_bad_header();
        test_gaps();
        test_reset_mid_load();
`ifdef NP_LOADER_CHK_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
